uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter BUSY_TIMEOUT, default 4, clocks to wait for uart_busy_i to rise after a launch.
REQ-003 clk  input  1  single clock for the module; all logic on the rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 wr_i  input  1  one-cycle push strobe from the bus data-register write decode.
REQ-006 data_i  input  8  byte to push, sampled with wr_i.
REQ-007 full_o  output  1  FIFO holds DEPTH entries.
REQ-008 empty_o  output  1  FIFO holds 0 entries.
REQ-009 level_o  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-010 overflow_o  output  1  sticky flag: a push was dropped.
REQ-011 clr_ovf_i  input  1  one-cycle strobe clearing overflow_o.
REQ-012 uart_wr_o  output  1  one-cycle transmit strobe to the UART wr_i.
REQ-013 uart_data_o  output  8  byte to the UART tx_data_i.
REQ-014 uart_busy_i  input  1  UART transmitter busy.

Function
REQ-015 Storage: circular buffer, write/read pointers $clog2(DEPTH)+1 bits wide, wrapping modulo 2*DEPTH; full/empty SHALL be derived from the pointers and SHALL be registered-state based, not combinational from wr_i.
REQ-016 Push: if wr_i=1 and the FIFO is not full, store data_i at the write pointer and increment the pointer at that edge.
REQ-017 Push when full: data dropped, pointers unchanged, overflow_o set at that edge, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-018 Simultaneous push and pop: both take effect; level_o unchanged.
REQ-019 clr_ovf_i and a dropped push in the same cycle: overflow_o SHALL end set (set wins).
REQ-020 FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: when the FIFO is not empty and uart_busy_i=0, pop one entry into uart_data_o, assert uart_wr_o for exactly the following cycle, then go to WAIT_BUSY; otherwise stay in IDLE.
REQ-022 WAIT_BUSY: if uart_busy_i=1, go to WAIT_DONE; if BUSY_TIMEOUT cycles elapse without busy, go to IDLE (lost-launch recovery).
REQ-023 WAIT_DONE: stay while uart_busy_i=1; on uart_busy_i=0, go to IDLE.
REQ-024 uart_data_o SHALL remain stable from the pop until the next pop.
REQ-025 uart_wr_o SHALL never be high in two consecutive cycles.
REQ-026 Latency: a wr_i sampled at edge k into an empty FIFO, with FSM in IDLE and busy low, SHALL produce uart_wr_o high in the cycle after edge k+1.
REQ-027 level_o, full_o and empty_o SHALL update at the same edge as the push or pop that changes them.
REQ-028 Bytes SHALL leave in push order, with no loss or duplication.

Reset
REQ-029 While reset_i=0: pointers=0, level_o=0, empty_o=1, full_o=0, overflow_o=0, uart_wr_o=0, uart_data_o=8'h00, FSM=IDLE.
REQ-030 Reset asserted mid-transfer SHALL discard all queued bytes. After release, no uart_wr_o until a new push.
REQ-031 Storage array contents need not be reset.

Verification
REQ-032 Push 8'h41 into an idle, empty FIFO with busy low -> uart_wr_o high exactly 2 edges later with uart_data_o=8'h41; level_o returns to 0.
REQ-033 Hold busy high and push 17 bytes with DEPTH=16 -> full_o=1, level_o=16, overflow_o=1; the 17th byte is absent from the drained output.
REQ-034 FIFO full with busy low in IDLE, push on the pop cycle -> push accepted, level_o stays 16, overflow_o stays 0.
REQ-035 Busy never rises after a launch -> FSM returns to IDLE after 4 cycles and launches the next queued byte; no double strobe.
REQ-036 Assert reset_i low while 5 bytes are queued and in WAIT_DONE -> all outputs at reset values immediately; after release, no uart_wr_o.
REQ-037 Push a random 64-byte stream with random busy durations -> output byte sequence equals the input sequence.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a bus data-register write decode and a UART transmitter.
// Queued bytes are launched one at a time with a single-cycle write strobe; a lost launch is recovered by timeout.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     wr_i,
    input  logic [7:0]               data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    input  logic                     clr_ovf_i,
    output logic                     uart_wr_o,
    output logic [7:0]               uart_data_o,
    input  logic                     uart_busy_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [TW-1:0] tmo_cnt;
    state_t        state;
    state_t        state_nxt;
    logic          launch;
    logic          push;
    logic          drop;

    // The extra pointer MSB tells a full buffer from an empty one when the indices match.
    assign level_o = wr_ptr - rd_ptr;
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign push = wr_i && (!full_o || launch);
    assign drop = wr_i && full_o && !launch;

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PTR_ONE;
            if (launch) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i)       overflow_o <= 1'b0;
        else if (drop)      overflow_o <= 1'b1;
        else if (clr_ovf_i) overflow_o <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i)                tmo_cnt <= '0;
        else if (state != WAIT_BUSY) tmo_cnt <= '0;
        else                         tmo_cnt <= tmo_cnt + TMO_ONE;
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (launch) state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy_i)              state_nxt = WAIT_DONE;
                else if (tmo_cnt == TMO_LAST) state_nxt = IDLE;
            end
            WAIT_DONE: begin
                if (!uart_busy_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        launch = 1'b0;
        if (state == IDLE && !empty_o && !uart_busy_i) launch = 1'b1;
    end

    // The strobe is registered, so it lasts one cycle and the FSM has already left IDLE.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            uart_wr_o   <= 1'b0;
            uart_data_o <= 8'h00;
        end else begin
            uart_wr_o <= launch;
            if (launch) uart_data_o <= mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo: a queue model of accepted bytes plus a simple UART busy responder.
module tb_uart_tx_fifo;

    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 4;
    localparam int LW           = $clog2(DEPTH) + 1;

    typedef enum {B_NORMAL, B_NEVER, B_HOLD} busy_mode_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          wr_i = 1'b0;
    logic [7:0]    data_i = 8'h00;
    logic          clr_ovf_i = 1'b0;
    logic          uart_busy_i = 1'b0;
    logic          full_o;
    logic          empty_o;
    logic [LW-1:0] level_o;
    logic          overflow_o;
    logic          uart_wr_o;
    logic [7:0]    uart_data_o;

    byte unsigned exp_q[$];
    int           launch_cyc[$];
    busy_mode_t   busy_mode = B_NORMAL;
    int           busy_len = 0;
    int           busy_cnt = 0;
    int           checks = 0;
    int           failures = 0;
    int           cycle_no = 0;
    int           launches = 0;
    bit           prev_wr = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .reset_i(reset_i), .wr_i(wr_i), .data_i(data_i),
        .full_o(full_o), .empty_o(empty_o), .level_o(level_o),
        .overflow_o(overflow_o), .clr_ovf_i(clr_ovf_i),
        .uart_wr_o(uart_wr_o), .uart_data_o(uart_data_o), .uart_busy_i(uart_busy_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance one clock and, at the falling edge, score launches, answer with busy and check occupancy.
    task automatic cycle();
        bit exp_empty, exp_full;
        @(negedge clk);
        cycle_no++;
        if (uart_wr_o === 1'b1) begin
            launches++;
            launch_cyc.push_back(cycle_no);
            checks++;
            if (prev_wr) begin
                failures++;
                $display("FAIL double_strobe cycle=%0d got two consecutive strobes expected one", cycle_no);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_launch cycle=%0d got=%h expected=no launch", cycle_no, uart_data_o);
            end else begin
                if (uart_data_o !== exp_q[0]) begin
                    failures++;
                    $display("FAIL byte_order cycle=%0d got=%h expected=%h", cycle_no, uart_data_o, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (busy_mode == B_NORMAL) begin
                uart_busy_i = 1'b1;
                busy_cnt = (busy_len > 0) ? busy_len : int'($urandom_range(1, 12));
            end
        end else if (busy_mode == B_NORMAL && busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) uart_busy_i = 1'b0;
        end
        prev_wr = (uart_wr_o === 1'b1);
        exp_empty = (exp_q.size() == 0);
        exp_full  = (exp_q.size() == DEPTH);
        checks++;
        if (level_o !== LW'(exp_q.size()) || empty_o !== exp_empty || full_o !== exp_full) begin
            failures++;
            $display("FAIL occupancy cycle=%0d got level=%0d empty=%b full=%b expected level=%0d empty=%b full=%b",
                     cycle_no, level_o, empty_o, full_o, exp_q.size(), exp_empty, exp_full);
        end
    endtask

    task automatic push(input logic [7:0] b, input bit accepted);
        wr_i = 1'b1;
        data_i = b;
        if (accepted) exp_q.push_back(b);
        cycle();
        wr_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || uart_busy_i) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got %0d bytes still queued expected 0", exp_q.size());
        end
        repeat (BUSY_TIMEOUT + 2) cycle();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (level_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0 || overflow_o !== 1'b0 ||
            uart_wr_o !== 1'b0 || uart_data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got level=%0d empty=%b full=%b ovf=%b wr=%b data=%h expected 0 1 0 0 0 00",
                     level_o, empty_o, full_o, overflow_o, uart_wr_o, uart_data_o);
        end
        reset_i = 1'b1;
        repeat (3) cycle();
        checks++;
        if (uart_wr_o !== 1'b0 || launches != 0) begin
            failures++;
            $display("FAIL reset_idle got launches=%0d expected 0", launches);
        end
    endtask

    task automatic test_latency();
        busy_mode = B_NORMAL;
        busy_len = 3;
        push(8'h41, 1'b1);
        checks++;
        if (uart_wr_o !== 1'b0) begin
            failures++;
            $display("FAIL latency_early got wr=%b expected 0 one edge after push", uart_wr_o);
        end
        cycle();
        checks++;
        if (uart_wr_o !== 1'b1 || uart_data_o !== 8'h41 || level_o !== '0) begin
            failures++;
            $display("FAIL latency got wr=%b data=%h level=%0d expected 1 41 0", uart_wr_o, uart_data_o, level_o);
        end
        drain(100);
        checks++;
        if (uart_data_o !== 8'h41) begin
            failures++;
            $display("FAIL data_hold got=%h expected=41", uart_data_o);
        end
    endtask

    task automatic test_overflow();
        busy_mode = B_HOLD;
        uart_busy_i = 1'b1;
        cycle();
        for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i), 1'b1);
        push(8'hEE, 1'b0);
        checks++;
        if (full_o !== 1'b1 || level_o !== LW'(DEPTH) || overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL overflow got full=%b level=%0d ovf=%b expected 1 %0d 1", full_o, level_o, overflow_o, DEPTH);
        end
        clr_ovf_i = 1'b1;
        cycle();
        clr_ovf_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b expected=0", overflow_o);
        end
        clr_ovf_i = 1'b1;
        push(8'hDD, 1'b0);
        clr_ovf_i = 1'b0;
        checks++;
        if (overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins got=%b expected=1", overflow_o);
        end
        cycle();
        checks++;
        if (overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got=%b expected=1", overflow_o);
        end
        clr_ovf_i = 1'b1;
        cycle();
        clr_ovf_i = 1'b0;
        busy_mode = B_NORMAL;
        busy_len = 0;
        busy_cnt = 0;
        uart_busy_i = 1'b0;
        drain(1000);
    endtask

    task automatic test_push_on_pop();
        busy_mode = B_HOLD;
        uart_busy_i = 1'b1;
        cycle();
        for (int i = 0; i < DEPTH; i++) push(8'h20 + 8'(i), 1'b1);
        busy_mode = B_NORMAL;
        busy_len = 2;
        busy_cnt = 0;
        uart_busy_i = 1'b0;
        push(8'h5A, 1'b1);
        checks++;
        if (uart_wr_o !== 1'b1 || level_o !== LW'(DEPTH) || full_o !== 1'b1 || overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL push_on_pop got wr=%b level=%0d full=%b ovf=%b expected 1 %0d 1 0",
                     uart_wr_o, level_o, full_o, overflow_o, DEPTH);
        end
        busy_len = 0;
        drain(1000);
    endtask

    task automatic test_lost_launch();
        busy_mode = B_NEVER;
        uart_busy_i = 1'b0;
        launch_cyc.delete();
        push(8'hA1, 1'b1);
        push(8'hA2, 1'b1);
        push(8'hA3, 1'b1);
        drain(200);
        checks++;
        if (launch_cyc.size() != 3) begin
            failures++;
            $display("FAIL lost_launch_count got=%0d expected=3", launch_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (launch_cyc[i] - launch_cyc[i-1] != BUSY_TIMEOUT + 1) begin
                    failures++;
                    $display("FAIL lost_launch_gap got=%0d expected=%0d",
                             launch_cyc[i] - launch_cyc[i-1], BUSY_TIMEOUT + 1);
                end
            end
        end
        busy_mode = B_NORMAL;
    endtask

    task automatic test_reset_mid();
        int snap;
        busy_mode = B_NORMAL;
        busy_len = 100;
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i), 1'b1);
        repeat (2) cycle();
        checks++;
        if (exp_q.size() != 5 || uart_busy_i !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_setup got queued=%0d busy=%b expected 5 1", exp_q.size(), uart_busy_i);
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if (level_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0 || overflow_o !== 1'b0 ||
            uart_wr_o !== 1'b0 || uart_data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid got level=%0d empty=%b full=%b ovf=%b wr=%b data=%h expected 0 1 0 0 0 00",
                     level_o, empty_o, full_o, overflow_o, uart_wr_o, uart_data_o);
        end
        exp_q.delete();
        busy_len = 0;
        busy_cnt = 0;
        uart_busy_i = 1'b0;
        cycle();
        reset_i = 1'b1;
        snap = launches;
        repeat (20) cycle();
        checks++;
        if (launches != snap) begin
            failures++;
            $display("FAIL reset_mid_quiet got %0d launches expected 0", launches - snap);
        end
    endtask

    task automatic test_random_stream();
        int start = launches;
        int g;
        busy_mode = B_NORMAL;
        busy_len = 0;
        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0) cycle();
            g = 0;
            while (exp_q.size() >= DEPTH && g < 500) begin
                cycle();
                g++;
            end
            push(8'($urandom), 1'b1);
        end
        drain(3000);
        checks++;
        if (launches - start != 64) begin
            failures++;
            $display("FAIL random_count got=%0d expected=64", launches - start);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_push_on_pop();
        test_lost_launch();
        test_reset_mid();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
